// File: rtl/dtree_pkg.sv
// ---------------------------------------------------------------------------
// dtree_pkg
// Shared definitions for the arrhythmia decision-tree classifier.
// Holds the feature frame geometry, the indices of the five features the tree
// actually consumes, and the state encoding of the feature loader.
// No ports (package).
// ---------------------------------------------------------------------------
package dtree_pkg;

    localparam int FEAT_W       = 8;
    localparam int NUM_FEATURES = 279;
    localparam int NUM_CAPTURE  = 5;
    localparam int IDX_W        = $clog2(NUM_FEATURES);

    // Captured feature indices; entry 0 is the lowest slice.
    // The classifier wrapper reads the same table so both stages agree on
    // which feature lands in which slot.
    localparam logic [NUM_CAPTURE-1:0][IDX_W-1:0] CAPTURE_IDX = {
        IDX_W'(278),
        IDX_W'(264),
        IDX_W'(235),
        IDX_W'(27),
        IDX_W'(13)
    };

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        STALL   = 2'd2
    } loader_state_t;

endpackage

// File: rtl/dtree_feature_loader.sv
// ---------------------------------------------------------------------------
// dtree_feature_loader
// Upstream stage of the decision-tree classifier. Receives one patient sample
// as a serial stream of NUM_FEATURES bytes (valid/ready), keeps the five
// features the tree uses in a shadow bank, and publishes them as a registered
// parallel set (valid/ready). Short and long frames are dropped and counted.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input byte handshake
//   in_data, in_last    feature byte and end-of-frame marker
//   x13..x278           captured feature set (registered)
//   feat_valid/ready    output set handshake
//   frame_err           one-cycle pulse per malformed frame
//   err_count           saturating count of malformed frames
// ---------------------------------------------------------------------------
module dtree_feature_loader #(
    parameter int NUM_FEATURES = dtree_pkg::NUM_FEATURES,
    parameter int FEAT_W       = dtree_pkg::FEAT_W,
    parameter int IDX0         = int'(dtree_pkg::CAPTURE_IDX[0]),
    parameter int IDX1         = int'(dtree_pkg::CAPTURE_IDX[1]),
    parameter int IDX2         = int'(dtree_pkg::CAPTURE_IDX[2]),
    parameter int IDX3         = int'(dtree_pkg::CAPTURE_IDX[3]),
    parameter int IDX4         = int'(dtree_pkg::CAPTURE_IDX[4]),
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FEAT_W-1:0]    in_data,
    input  logic                 in_last,
    output logic [FEAT_W-1:0]    x13,
    output logic [FEAT_W-1:0]    x27,
    output logic [FEAT_W-1:0]    x235,
    output logic [FEAT_W-1:0]    x264,
    output logic [FEAT_W-1:0]    x278,
    output logic                 feat_valid,
    input  logic                 feat_ready,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    import dtree_pkg::*;

    localparam int IDX_BITS = $clog2(NUM_FEATURES);
    localparam int NCAP     = 5;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_FEATURES - 1);
    localparam logic [NCAP-1:0][IDX_BITS-1:0] CAP_IDX = {
        IDX_BITS'(IDX4), IDX_BITS'(IDX3), IDX_BITS'(IDX2),
        IDX_BITS'(IDX1), IDX_BITS'(IDX0)
    };

    loader_state_t          r_state;
    logic [IDX_BITS-1:0]    r_idx;
    logic [FEAT_W-1:0]      r_shadow [NCAP];
    logic [FEAT_W-1:0]      r_out    [NCAP];
    logic                   r_feat_valid;
    logic                   r_frame_err;
    logic [ERR_CNT_W-1:0]   r_err_count;

    logic                   w_accept;
    logic                   w_collect;
    logic                   w_at_last;
    logic                   w_good;
    logic                   w_short;
    logic                   w_long;
    logic                   w_slot_free;
    logic                   w_capture;
    logic [FEAT_W-1:0]      w_shadow_next [NCAP];

    // The loader only refuses bytes while a finished frame waits for the
    // output slot, so in_ready is a pure decode of the state.
    assign in_ready    = (r_state != STALL);
    assign w_accept    = in_valid && in_ready;
    assign w_collect   = (r_state == COLLECT);
    assign w_at_last   = (r_idx == LAST_IDX);
    assign w_good      = w_accept && w_collect &&  in_last &&  w_at_last;
    assign w_short     = w_accept && w_collect &&  in_last && !w_at_last;
    assign w_long      = w_accept && w_collect && !in_last &&  w_at_last;
    assign w_slot_free = !r_feat_valid || feat_ready;
    // The closing byte of a short frame must not disturb the shadow bank.
    assign w_capture   = w_accept && w_collect && !w_short;

    // Next shadow contents: this is also what a good frame publishes, so the
    // final byte of the frame reaches the output without an extra cycle.
    always_comb begin
        for (int k = 0; k < NCAP; k++) begin
            w_shadow_next[k] = r_shadow[k];
            if (w_capture && (r_idx == CAP_IDX[k])) begin
                w_shadow_next[k] = in_data;
            end
        end
    end

    // Frame FSM, byte counter, shadow/output banks and error bookkeeping.
    // feat_valid is cleared on a consumer handshake by default and re-set
    // later in the block when a new set is loaded in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= COLLECT;
            r_idx        <= '0;
            r_feat_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_count  <= '0;
            for (int k = 0; k < NCAP; k++) begin
                r_shadow[k] <= '0;
                r_out[k]    <= '0;
            end
        end else begin
            r_frame_err <= 1'b0;
            for (int k = 0; k < NCAP; k++) begin
                r_shadow[k] <= w_shadow_next[k];
            end
            if (r_feat_valid && feat_ready) begin
                r_feat_valid <= 1'b0;
            end

            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        if (in_last || w_at_last) begin
                            r_idx <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end

                        if (w_good) begin
                            if (w_slot_free) begin
                                r_out        <= w_shadow_next;
                                r_feat_valid <= 1'b1;
                            end else begin
                                r_state <= STALL;
                            end
                        end else if (w_short) begin
                            r_frame_err <= 1'b1;
                            if (r_err_count != '1) begin
                                r_err_count <= r_err_count + 1'b1;
                            end
                        end else if (w_long) begin
                            r_state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // Excess bytes of an over-long frame are swallowed.
                    if (w_accept && in_last) begin
                        r_frame_err <= 1'b1;
                        if (r_err_count != '1) begin
                            r_err_count <= r_err_count + 1'b1;
                        end
                        r_state <= COLLECT;
                    end
                end

                STALL: begin
                    // feat_valid is necessarily high here; the handshake
                    // frees the slot and the parked frame moves in.
                    if (feat_ready) begin
                        r_out        <= r_shadow;
                        r_feat_valid <= 1'b1;
                        r_state      <= COLLECT;
                    end
                end

                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

    assign x13        = r_out[0];
    assign x27        = r_out[1];
    assign x235       = r_out[2];
    assign x264       = r_out[3];
    assign x278       = r_out[4];
    assign feat_valid = r_feat_valid;
    assign frame_err  = r_frame_err;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_dtree_feature_loader.sv
// ---------------------------------------------------------------------------
// tb_dtree_feature_loader
// Directed bench for dtree_feature_loader: good frames, back-to-back frames,
// output stall, short frame, long frames with counter saturation, and reset
// in the middle of a frame. Expected values are hand-computed from the
// feature index (data = (index + base) mod 256).
// ---------------------------------------------------------------------------
module tb_dtree_feature_loader;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic [7:0] x13;
    logic [7:0] x27;
    logic [7:0] x235;
    logic [7:0] x264;
    logic [7:0] x278;
    logic       feat_valid;
    logic       feat_ready;
    logic       frame_err;
    logic [7:0] err_count;

    int checks      = 0;
    int errors      = 0;
    int stallCycles = 0;
    int hsCount     = 0;

    dtree_feature_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .x13        (x13),
        .x27        (x27),
        .x235       (x235),
        .x264       (x264),
        .x278       (x278),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .frame_err  (frame_err),
        .err_count  (err_count)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts output-side handshakes so back-to-back publishing can be seen.
    always @(posedge clk) begin
        if (!rst && feat_valid && feat_ready) begin
            hsCount <= hsCount + 1;
        end
    end

    // Last-resort guard so the run can never hang.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of input, reports whether the byte was taken, and
    // leaves time 1 unit after the clock edge for sampling.
    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic l, output logic accepted);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        accepted = v && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        logic acc;
        applyStimulus(1'b0, 8'h00, 1'b0, acc);
    endtask

    // Streams nBytes bytes with data (i+base) mod 256, marking the last one
    // with in_last when withLast is set. Returns 1 unit after the edge that
    // accepted the final byte, with in_valid dropped.
    task automatic sendFrame(input int nBytes, input int base, input bit withLast);
        int   i;
        int   waitCycles;
        logic acc;
        i = 0;
        waitCycles = 0;
        while (i < nBytes) begin
            applyStimulus(1'b1, 8'((i + base) & 255), withLast && (i == nBytes - 1), acc);
            if (acc) begin
                i++;
                waitCycles = 0;
            end else begin
                stallCycles++;
                waitCycles++;
                if (waitCycles > 2000) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sendFrame_timeout observed=%0d expected=%0d", i, nBytes);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic checkSet(input string tag, input int e13, input int e27,
                            input int e235, input int e264, input int e278);
        checkOutput({tag, "_x13"},  32'(x13),  32'(e13));
        checkOutput({tag, "_x27"},  32'(x27),  32'(e27));
        checkOutput({tag, "_x235"}, 32'(x235), 32'(e235));
        checkOutput({tag, "_x264"}, 32'(x264), 32'(e264));
        checkOutput({tag, "_x278"}, 32'(x278), 32'(e278));
    endtask

    initial begin
        int hs0;
        int stall0;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_last    = 1'b0;
        feat_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_in_ready",   32'(in_ready),   32'd1);
        checkOutput("rst_feat_valid", 32'(feat_valid), 32'd0);
        checkOutput("rst_frame_err",  32'(frame_err),  32'd0);
        checkOutput("rst_err_count",  32'(err_count),  32'd0);
        checkSet("rst", 0, 0, 0, 0, 0);

        // Single good frame, consumer ready
        $display("[TB] good frame");
        sendFrame(279, 0, 1'b1);
        checkOutput("good_feat_valid", 32'(feat_valid), 32'd1);
        checkOutput("good_frame_err",  32'(frame_err),  32'd0);
        checkSet("good", 13, 27, 235, 8, 22);
        idleCycle();
        checkOutput("good_consumed", 32'(feat_valid), 32'd0);

        // Two back-to-back good frames
        $display("[TB] back-to-back frames");
        hs0    = hsCount;
        stall0 = stallCycles;
        sendFrame(279, 0, 1'b1);
        checkOutput("b2b1_feat_valid", 32'(feat_valid), 32'd1);
        checkSet("b2b1", 13, 27, 235, 8, 22);
        sendFrame(279, 1, 1'b1);
        checkOutput("b2b2_feat_valid", 32'(feat_valid), 32'd1);
        checkSet("b2b2", 14, 28, 236, 9, 23);
        idleCycle();
        checkOutput("b2b_handshakes", 32'(hsCount - hs0),     32'd2);
        checkOutput("b2b_no_stall",   32'(stallCycles - stall0), 32'd0);
        checkOutput("b2b_consumed",   32'(feat_valid),        32'd0);

        // Second frame completes while the consumer is stalled
        $display("[TB] output stall");
        feat_ready = 1'b0;
        sendFrame(279, 0, 1'b1);
        checkOutput("stallA_feat_valid", 32'(feat_valid), 32'd1);
        sendFrame(279, 1, 1'b1);
        checkOutput("stall_in_ready",   32'(in_ready),   32'd0);
        checkOutput("stall_feat_valid", 32'(feat_valid), 32'd1);
        checkSet("stall_hold", 13, 27, 235, 8, 22);
        idleCycle();
        idleCycle();
        idleCycle();
        checkOutput("stall_in_ready_late", 32'(in_ready), 32'd0);
        checkSet("stall_hold_late", 13, 27, 235, 8, 22);
        feat_ready = 1'b1;
        idleCycle();
        checkOutput("unstall_in_ready",   32'(in_ready),   32'd1);
        checkOutput("unstall_feat_valid", 32'(feat_valid), 32'd1);
        checkSet("unstall", 14, 28, 236, 9, 23);
        idleCycle();
        checkOutput("unstall_consumed", 32'(feat_valid), 32'd0);

        // Short frame: in_last at index 100
        $display("[TB] short frame");
        sendFrame(101, 0, 1'b1);
        checkOutput("short_frame_err",  32'(frame_err),  32'd1);
        checkOutput("short_err_count",  32'(err_count),  32'd1);
        checkOutput("short_feat_valid", 32'(feat_valid), 32'd0);
        idleCycle();
        checkOutput("short_err_pulse", 32'(frame_err), 32'd0);
        sendFrame(279, 3, 1'b1);
        checkOutput("after_short_valid", 32'(feat_valid), 32'd1);
        checkOutput("after_short_err",   32'(frame_err),  32'd0);
        checkSet("after_short", 16, 30, 238, 11, 25);
        idleCycle();

        // Long frames: 285 bytes each, counter must saturate
        $display("[TB] long frames");
        stall0 = stallCycles;
        sendFrame(285, 0, 1'b1);
        checkOutput("long_no_stall",   32'(stallCycles - stall0), 32'd0);
        checkOutput("long_frame_err",  32'(frame_err),  32'd1);
        checkOutput("long_err_count",  32'(err_count),  32'd2);
        checkOutput("long_feat_valid", 32'(feat_valid), 32'd0);
        for (int n = 0; n < 253; n++) begin
            sendFrame(285, 0, 1'b1);
        end
        checkOutput("long_count_255", 32'(err_count), 32'd255);
        sendFrame(285, 0, 1'b1);
        sendFrame(285, 0, 1'b1);
        checkOutput("long_saturated",     32'(err_count),  32'd255);
        checkOutput("long_sat_frame_err", 32'(frame_err),  32'd1);
        checkOutput("long_sat_no_pub",    32'(feat_valid), 32'd0);
        idleCycle();

        // Reset in the middle of a frame with an unconsumed set pending
        $display("[TB] mid-frame reset");
        feat_ready = 1'b0;
        sendFrame(279, 4, 1'b1);
        checkOutput("pend_feat_valid", 32'(feat_valid), 32'd1);
        checkOutput("pend_x13",        32'(x13),        32'd17);
        sendFrame(150, 0, 1'b0);
        rst = 1'b1;
        idleCycle();
        rst = 1'b0;
        checkOutput("midrst_in_ready",   32'(in_ready),   32'd1);
        checkOutput("midrst_feat_valid", 32'(feat_valid), 32'd0);
        checkOutput("midrst_err_count",  32'(err_count),  32'd0);
        checkOutput("midrst_x13",        32'(x13),        32'd0);
        feat_ready = 1'b1;
        sendFrame(279, 0, 1'b1);
        checkOutput("postrst_feat_valid", 32'(feat_valid), 32'd1);
        checkOutput("postrst_frame_err",  32'(frame_err),  32'd0);
        checkOutput("postrst_err_count",  32'(err_count),  32'd0);
        checkSet("postrst", 13, 27, 235, 8, 22);
        idleCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
